// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and lane helpers for the systolic array west-edge feeder
package systolic_pkg;

    typedef enum logic {STREAM, DRAIN} feeder_state_e;

    localparam int edge_lanes_c = 4;
    localparam int edge_width_c = 8;

    function automatic int lane_lsb(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line: enable-gated shift register of depth_p stages with async active-low clear
module skew_delay_line #(
    parameter int width_p = 8,
    parameter int depth_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);
    logic [width_p-1:0] sr [depth_p];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < depth_p; i++) sr[i] <= '0;
        end else if (en_i) begin
            sr[0] <= data_i;
            for (int i = 1; i < depth_p; i++) sr[i] <= sr[i-1];
        end
    end

    assign data_o = sr[depth_p-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: pops row vectors and emits them lane-skewed, padding each tile with zero drain steps
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int lanes_p = edge_lanes_c,
    parameter int width_p = edge_width_c,
    parameter int len_p   = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       valid_i,
    input  logic [lanes_p*width_p-1:0] data_i,
    output logic                       yumi_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [lanes_p*width_p-1:0] data_o,
    output logic                       last_o
);
    localparam int vc_w = $clog2(len_p + 1);
    localparam int dc_w = lanes_p > 1 ? $clog2(lanes_p) : 1;
    localparam logic [vc_w-1:0] vec_end_c   = vc_w'(len_p - 1);
    localparam logic [dc_w-1:0] drain_end_c = dc_w'(lanes_p > 1 ? lanes_p - 2 : 0);

    feeder_state_e   state;
    logic [vc_w-1:0] vec_cnt;
    logic [dc_w-1:0] drain_cnt;
    logic            adv, drain, vec_end, drain_end;

    assign drain     = state == DRAIN;
    assign adv       = (~valid_o | ready_i) & (drain | valid_i);
    assign yumi_o    = adv & ~drain;
    assign vec_end   = vec_cnt == vec_end_c;
    assign drain_end = drain_cnt == drain_end_c;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state     <= STREAM;
            vec_cnt   <= '0;
            drain_cnt <= '0;
            valid_o   <= 1'b0;
            last_o    <= 1'b0;
        end else if (adv) begin
            valid_o <= 1'b1;
            if (drain) begin
                last_o    <= drain_end;
                drain_cnt <= drain_cnt + 1'b1;
                state     <= drain_end ? STREAM : DRAIN;
            end else begin
                // single-lane arrays have no drain, so the tile ends on its last vector
                last_o  <= vec_end && (lanes_p == 1);
                vec_cnt <= vec_end ? '0 : vec_cnt + 1'b1;
                if (vec_end && (lanes_p > 1)) begin
                    state     <= DRAIN;
                    drain_cnt <= '0;
                end
            end
        end else if (ready_i) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
        end
    end

    for (genvar k = 0; k < lanes_p; k++) begin : g_lane
        skew_delay_line #(.width_p(width_p), .depth_p(k + 1)) u_dl (
            .clk_i    (clk_i),
            .reset_ni (reset_ni),
            .en_i     (adv),
            .data_i   (drain ? '0 : data_i[lane_lsb(k, width_p) +: width_p]),
            .data_o   (data_o[lane_lsb(k, width_p) +: width_p])
        );
    end

endmodule
